// File: rtl/ntt2_pipe_pkg.sv
// Shared constants and modular add/sub helpers for the ntt2_pipe butterfly datapath
// over P = 2^33 - 2^20 + 1.
package ntt2_pipe_pkg;

    localparam int DW = 33;
    localparam logic [DW:0] TWO33 = 34'h2_0000_0000;
    localparam logic [DW:0] TWO20 = 34'h0_0010_0000;
    localparam logic [DW-1:0] P_MOD = DW'(TWO33 - TWO20 + 34'd1);
    localparam int SH20 = $clog2(TWO20);
    localparam int LAT_C = 6;

    typedef logic [DW-1:0] fe_t;

    // (a + b) mod p for reduced operands: one conditional subtract suffices
    function automatic fe_t add_mod(input fe_t a, input fe_t b, input fe_t p);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, p}) ? DW'(s - {1'b0, p}) : s[DW-1:0];
    endfunction

    // (a - b) mod p for reduced operands: add p back when the difference goes negative
    function automatic fe_t sub_mod(input fe_t a, input fe_t b, input fe_t p);
        return (a >= b) ? fe_t'(a - b) : DW'({1'b0, a} + {1'b0, p} - {1'b0, b});
    endfunction

endpackage

// File: rtl/ntt_modred_p33.sv
// Three-stage folding reduction of a 66-bit product to a value < P, using
// 2^33 == 2^20 - 1 (mod P). Output t appears three cycles after m is presented.
module ntt_modred_p33
    import ntt2_pipe_pkg::*;
#(
    parameter logic [DW-1:0] P = P_MOD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2*DW-1:0] m,
    output logic [DW-1:0]   t
);

    logic [53:0]   r1_s;
    logic [41:0]   r2_s;
    logic [DW:0]   r3_s;
    logic [DW-1:0] t_s;

    logic [53:0]   r1_r;
    logic [41:0]   r2_r;
    logic [DW-1:0] t_r;

    // Each fold keeps L and replaces H*2^33 with H*2^20 - H; all terms stay non-negative
    always_comb begin
        r1_s = 54'(m[DW-1:0]) + (54'(m[2*DW-1:DW]) << SH20) - 54'(m[2*DW-1:DW]);
        r2_s = 42'(r1_r[DW-1:0]) + (42'(r1_r[53:DW]) << SH20) - 42'(r1_r[53:DW]);
        r3_s = 34'(r2_r[DW-1:0]) + (34'(r2_r[41:DW]) << SH20) - 34'(r2_r[41:DW]);
        // r3 < 2^33 + 2^29 < 2P, so a single correction lands in [0, P)
        t_s = (r3_s >= {1'b0, P}) ? DW'(r3_s - {1'b0, P}) : r3_s[DW-1:0];
    end

    // Fold pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r1_r <= '0;
            r2_r <= '0;
            t_r  <= '0;
        end else begin
            r1_r <= r1_s;
            r2_r <= r2_s;
            t_r  <= t_s;
        end
    end

    assign t = t_r;

endmodule

// File: rtl/ntt2_pipe.sv
// Six-stage radix-2 NTT butterfly mod P = 2^33 - 2^20 + 1, one butterfly per clock.
// Default is Cooley-Tukey; define NTT2_GS_EN for the Gentleman-Sande (inverse) form.
module ntt2_pipe
    import ntt2_pipe_pkg::*;
#(
    parameter logic [DW-1:0] P   = P_MOD,
    parameter int            LAT = LAT_C
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] xin,
    input  logic [DW-1:0] yin,
    input  logic [DW-1:0] wr,
    input  logic          en,
    output logic [DW-1:0] xout,
    output logic [DW-1:0] yout,
    output logic          valid
);

    logic [DW-1:0]   x_r1;
    logic [DW-1:0]   y_r1;
    logic [DW-1:0]   w_r1;
    logic [LAT-1:0]  vld_r;
    logic [2*DW-1:0] m_r;
    logic [DW-1:0]   t_s;
    logic [DW-1:0]   xout_r;
    logic [DW-1:0]   yout_r;

    // Input capture and the valid chain; en never gates data, it only rides alongside
    always_ff @(posedge clk) begin
        if (reset) begin
            x_r1  <= '0;
            y_r1  <= '0;
            w_r1  <= '0;
            vld_r <= '0;
        end else begin
            x_r1  <= xin;
            y_r1  <= yin;
            w_r1  <= wr;
            vld_r <= {vld_r[LAT-2:0], en};
        end
    end

`ifdef NTT2_GS_EN
    logic [DW-1:0] s_r2;
    logic [DW-1:0] d_r2;
    logic [DW-1:0] w_r2;
    logic [DW-1:0] s_r3;
    logic [DW-1:0] s_r4;
    logic [DW-1:0] s_r5;

    // Add/sub first, then (x - y)*w; the sum is delayed to meet the reduced product
    always_ff @(posedge clk) begin
        if (reset) begin
            s_r2   <= '0;
            d_r2   <= '0;
            w_r2   <= '0;
            m_r    <= '0;
            s_r3   <= '0;
            s_r4   <= '0;
            s_r5   <= '0;
            xout_r <= '0;
        end else begin
            s_r2   <= add_mod(x_r1, y_r1, P);
            d_r2   <= sub_mod(x_r1, y_r1, P);
            w_r2   <= w_r1;
            m_r    <= (2*DW)'(d_r2) * (2*DW)'(w_r2);
            s_r3   <= s_r2;
            s_r4   <= s_r3;
            s_r5   <= s_r4;
            xout_r <= s_r5;
        end
    end

    ntt_modred_p33 #(.P(P)) u_red (
        .clk   (clk),
        .reset (reset),
        .m     (m_r),
        .t     (t_s)
    );

    // The reducer's last stage is S6, so its register drives yout directly
    assign yout_r = t_s;
`else
    logic [DW-1:0] x_r2;
    logic [DW-1:0] x_r3;
    logic [DW-1:0] x_r4;
    logic [DW-1:0] x_r5;

    // Product y*w in S2 with x delayed alongside; butterfly add/sub in S6
    always_ff @(posedge clk) begin
        if (reset) begin
            m_r    <= '0;
            x_r2   <= '0;
            x_r3   <= '0;
            x_r4   <= '0;
            x_r5   <= '0;
            xout_r <= '0;
            yout_r <= '0;
        end else begin
            m_r    <= (2*DW)'(y_r1) * (2*DW)'(w_r1);
            x_r2   <= x_r1;
            x_r3   <= x_r2;
            x_r4   <= x_r3;
            x_r5   <= x_r4;
            xout_r <= add_mod(x_r5, t_s, P);
            yout_r <= sub_mod(x_r5, t_s, P);
        end
    end

    ntt_modred_p33 #(.P(P)) u_red (
        .clk   (clk),
        .reset (reset),
        .m     (m_r),
        .t     (t_s)
    );
`endif

    assign xout  = xout_r;
    assign yout  = yout_r;
    assign valid = vld_r[LAT-1];

endmodule

// File: tb/tb_ntt2_pipe.sv
// Scoreboard bench for ntt2_pipe: expected results are queued with their due cycle
// when driven and compared every cycle on the falling edge.
module tb_ntt2_pipe;

    localparam logic [32:0] PM = 33'h1_FFF0_0001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [32:0] xin = 33'd0;
    logic [32:0] yin = 33'd0;
    logic [32:0] wr = 33'd0;
    logic [32:0] xout;
    logic [32:0] yout;
    logic        valid;

    typedef struct {
        int          due;
        logic [32:0] xo;
        logic [32:0] yo;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;

    ntt2_pipe dut (
        .clk   (clk),
        .reset (reset),
        .xin   (xin),
        .yin   (yin),
        .wr    (wr),
        .en    (en),
        .xout  (xout),
        .yout  (yout),
        .valid (valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic void model(input logic [32:0] x, input logic [32:0] y,
                                  input logic [32:0] w,
                                  output logic [32:0] xo, output logic [32:0] yo);
        logic [65:0] t;
`ifdef NTT2_GS_EN
        xo = 33'((66'(x) + 66'(y)) % 66'(PM));
        t  = ((66'(x) + 66'(PM) - 66'(y)) % 66'(PM)) * 66'(w) % 66'(PM);
        yo = 33'(t);
`else
        t  = (66'(y) * 66'(w)) % 66'(PM);
        xo = 33'((66'(x) + t) % 66'(PM));
        yo = 33'((66'(x) + 66'(PM) - t) % 66'(PM));
`endif
    endfunction

    // Output checker: a due entry must appear exactly on its cycle, otherwise valid stays low
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            check("valid", 33'(valid), 33'd1);
            check("xout", xout, q[0].xo);
            check("yout", yout, q[0].yo);
            void'(q.pop_front());
        end else begin
            check("idle_valid", 33'(valid), 33'd0);
        end
    end

    // Called at posedge+1; drives one cycle of inputs and queues the expectation
    task automatic step(input logic e, input logic [32:0] x, input logic [32:0] y,
                        input logic [32:0] w, input logic [32:0] ex, input logic [32:0] ey);
        exp_t ent;
        xin = x;
        yin = y;
        wr  = w;
        en  = e;
        if (e && !reset) begin
            ent.due = cyc + 6;
            ent.xo  = ex;
            ent.yo  = ey;
            q.push_back(ent);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [32:0] x, input logic [32:0] y, input logic [32:0] w);
        logic [32:0] ex, ey;
        model(x, y, w, ex, ey);
        step(1'b1, x, y, w, ex, ey);
    endtask

    task automatic send_k(input logic [32:0] x, input logic [32:0] y, input logic [32:0] w,
                          input logic [32:0] kx, input logic [32:0] ky);
`ifdef NTT2_GS_EN
        send(x, y, w);
`else
        step(1'b1, x, y, w, kx, ky);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 33'd0, 33'd0, 33'd0, 33'd0, 33'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 33'(valid), 33'd0);
        check("rst_xout", xout, 33'd0);
        check("rst_yout", yout, 33'd0);
        reset = 1'b0;

        // Directed vectors, back to back
        send_k(33'd5, 33'd3, 33'd1, 33'd8, 33'd2);
        send_k(33'd3, 33'd5, 33'd1, 33'd8, PM - 33'd2);
        send_k(33'd0, 33'h0_FFFF_FFFF, 33'd1024, 33'd536869376, 33'd8052016641);
        send_k(33'd10, 33'd4, PM - 33'd1, 33'd6, 33'd14);
        send_k(PM - 33'd1, PM - 33'd1, PM - 33'd1, 33'd0, PM - 33'd2);
        idle(8);

        // Single-cycle en pulse
        send(33'd123456789, 33'd987654321, 33'd1024);
        idle(10);

        // Back-to-back random stream
        for (int i = 0; i < 24; i++) send({1'b0, $urandom()}, {1'b0, $urandom()}, 33'd1024);
        for (int i = 0; i < 8; i++)
            send(33'($urandom_range(0, 1000)) + PM - 33'd1001, {1'b0, $urandom()}, PM - 33'd2);
        idle(8);

        // Reset mid-stream: in-flight results are discarded
        for (int i = 0; i < 4; i++) send({1'b0, $urandom()}, {1'b0, $urandom()}, 33'd1024);
        reset = 1'b1;
        while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
        step(1'b1, 33'd7, 33'd7, 33'd7, 33'd0, 33'd0);
        check("midrst_valid", 33'(valid), 33'd0);
        check("midrst_xout", xout, 33'd0);
        check("midrst_yout", yout, 33'd0);
        // Simultaneous reset and en: input must be dropped
        step(1'b1, 33'd9, 33'd9, 33'd9, 33'd0, 33'd0);
        reset = 1'b0;
        idle(8);
        send(33'd5, 33'd3, 33'd1);
        idle(3);
        send(33'd1000, 33'd2000, PM - 33'd1);
        idle(2);

        // Drain with a bounded wait
        for (int i = 0; i < 40 && q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 33'(q.size()), 33'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
